// File: rtl/dest_drain_arbiter_if.sv
// Read-side bundle for dest_drain_arbiter: FIFO pop/empty/data for D0 and D1,
// plus the merged valid/ready output stream and the per-destination counters.
interface dest_drain_arbiter_if #(
    parameter int DATA_SIZE = 6,
    parameter int CNT_W     = 8
);
    logic                 fifo_empty_d0;
    logic                 fifo_empty_d1;
    logic [DATA_SIZE-1:0] data_out_0;
    logic [DATA_SIZE-1:0] data_out_1;
    logic                 pop_d0;
    logic                 pop_d1;
    logic                 ready_in;
    logic                 valid_out;
    logic [DATA_SIZE-1:0] data_out;
    logic                 dest_out;
    logic [CNT_W-1:0]     cnt_d0;
    logic [CNT_W-1:0]     cnt_d1;

    modport master (
        input  fifo_empty_d0, fifo_empty_d1, data_out_0, data_out_1, ready_in,
        output pop_d0, pop_d1, valid_out, data_out, dest_out, cnt_d0, cnt_d1
    );

    modport slave (
        output fifo_empty_d0, fifo_empty_d1, data_out_0, data_out_1, ready_in,
        input  pop_d0, pop_d1, valid_out, data_out, dest_out, cnt_d0, cnt_d1
    );
endinterface

// File: rtl/dest_drain_arbiter.sv
// Drains destination FIFOs D0/D1 into one dest-tagged valid/ready stream.
// Define STRICT_PRIO_EN to give D0 strict priority; default is round-robin.
module dest_drain_arbiter #(
    parameter int DATA_SIZE = 6,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset_L,
    dest_drain_arbiter_if.master bus
);
    localparam logic [CNT_W-1:0]     CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]     CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [DATA_SIZE-1:0] DATA_ZERO = {DATA_SIZE{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2
    } state_t;

    state_t               state_r, state_nxt_s;
    logic                 rr_ptr_r, rr_ptr_nxt_s;
    logic [1:0]           occ_r, occ_nxt_s;
    logic [DATA_SIZE-1:0] head_data_r, head_data_nxt_s;
    logic [DATA_SIZE-1:0] tail_data_r, tail_data_nxt_s;
    logic                 head_dest_r, head_dest_nxt_s;
    logic                 tail_dest_r, tail_dest_nxt_s;
    logic [CNT_W-1:0]     cnt_d0_r, cnt_d1_r;

    logic                 inflight_s, cap_dest_s, xfer_s, credit_ok_s;
    logic                 elig0_s, elig1_s, gnt0_s, gnt1_s;
    logic [DATA_SIZE-1:0] cap_data_s;
    logic [2:0]           load_s;

    // The FSM state doubles as the in-flight flag and the empty-lag guard:
    // RDx means X was popped last cycle and its data is on data_out_x now.
    assign inflight_s  = (state_r != IDLE);
    assign cap_dest_s  = (state_r == RD1);
    assign cap_data_s  = cap_dest_s ? bus.data_out_1 : bus.data_out_0;
    assign xfer_s      = (occ_r != 2'd0) && bus.ready_in;
    assign load_s      = {1'b0, occ_r} + {2'b00, inflight_s};
    assign credit_ok_s = load_s < (3'd2 + {2'b00, xfer_s});
    assign elig0_s     = reset_L && credit_ok_s && !bus.fifo_empty_d0 && (state_r != RD0);
    assign elig1_s     = reset_L && credit_ok_s && !bus.fifo_empty_d1 && (state_r != RD1);

    // Grant selection among eligible FIFOs, at most one pop per cycle.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
`ifdef STRICT_PRIO_EN
        if (elig0_s) begin
            gnt0_s = 1'b1;
        end else if (elig1_s) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
        end
`else
        if (elig0_s && elig1_s) begin
            if (rr_ptr_r) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b1;
            end
        end else if (elig0_s) begin
            gnt0_s = 1'b1;
        end else if (elig1_s) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
        end
`endif
    end

    // Next FSM state follows this cycle's grant; pointer moves past the granted FIFO.
    always_comb begin
        state_nxt_s  = IDLE;
        rr_ptr_nxt_s = rr_ptr_r;
        case (state_r)
            IDLE, RD0, RD1: begin
                if (gnt0_s) begin
                    state_nxt_s  = RD0;
                    rr_ptr_nxt_s = 1'b1;
                end else if (gnt1_s) begin
                    state_nxt_s  = RD1;
                    rr_ptr_nxt_s = 1'b0;
                end else begin
                    state_nxt_s  = IDLE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Two-entry skid buffer: capture lands behind the head, transfer shifts tail forward.
    always_comb begin
        occ_nxt_s       = occ_r;
        head_data_nxt_s = head_data_r;
        head_dest_nxt_s = head_dest_r;
        tail_data_nxt_s = tail_data_r;
        tail_dest_nxt_s = tail_dest_r;
        case ({inflight_s, xfer_s})
            2'b11: begin
                if (occ_r == 2'd2) begin
                    head_data_nxt_s = tail_data_r;
                    head_dest_nxt_s = tail_dest_r;
                    tail_data_nxt_s = cap_data_s;
                    tail_dest_nxt_s = cap_dest_s;
                end else begin
                    head_data_nxt_s = cap_data_s;
                    head_dest_nxt_s = cap_dest_s;
                end
            end
            2'b10: begin
                if (occ_r == 2'd0) begin
                    head_data_nxt_s = cap_data_s;
                    head_dest_nxt_s = cap_dest_s;
                end else begin
                    tail_data_nxt_s = cap_data_s;
                    tail_dest_nxt_s = cap_dest_s;
                end
                occ_nxt_s = occ_r + 2'd1;
            end
            2'b01: begin
                head_data_nxt_s = tail_data_r;
                head_dest_nxt_s = tail_dest_r;
                occ_nxt_s       = occ_r - 2'd1;
            end
            default: occ_nxt_s = occ_r;
        endcase
    end

    // Arbiter state and round-robin pointer.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_r  <= IDLE;
            rr_ptr_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end

    // Skid buffer storage and per-destination capture counters.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            occ_r       <= 2'd0;
            head_data_r <= DATA_ZERO;
            head_dest_r <= 1'b0;
            tail_data_r <= DATA_ZERO;
            tail_dest_r <= 1'b0;
            cnt_d0_r    <= CNT_ZERO;
            cnt_d1_r    <= CNT_ZERO;
        end else begin
            occ_r       <= occ_nxt_s;
            head_data_r <= head_data_nxt_s;
            head_dest_r <= head_dest_nxt_s;
            tail_data_r <= tail_data_nxt_s;
            tail_dest_r <= tail_dest_nxt_s;
            if (inflight_s && cap_dest_s) begin
                cnt_d1_r <= cnt_d1_r + CNT_ONE;
            end else if (inflight_s) begin
                cnt_d0_r <= cnt_d0_r + CNT_ONE;
            end
        end
    end

    assign bus.pop_d0    = gnt0_s;
    assign bus.pop_d1    = gnt1_s;
    assign bus.valid_out = (occ_r != 2'd0);
    assign bus.data_out  = head_data_r;
    assign bus.dest_out  = head_dest_r;
    assign bus.cnt_d0    = cnt_d0_r;
    assign bus.cnt_d1    = cnt_d1_r;
endmodule

// File: tb/tb_dest_drain_arbiter.sv
// Self-checking bench for dest_drain_arbiter: FIFO models, hand-derived vector
// tables, directed corner sequences and a queue-based reference model.
module tb_dest_drain_arbiter;
    localparam int DW = 6;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    always #5 clk = ~clk;

    dest_drain_arbiter_if #(.DATA_SIZE(DW), .CNT_W(CW)) bus ();
    dest_drain_arbiter #(.DATA_SIZE(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset_L(reset_L), .bus(bus.master));

    // FIFO models: registered read data and an empty flag that lags by one cycle
    logic          empty0 = 1'b1, empty1 = 1'b1;
    logic [DW-1:0] rd0 = '0, rd1 = '0;
    logic [DW-1:0] q0[$], q1[$];
    assign bus.fifo_empty_d0 = empty0;
    assign bus.fifo_empty_d1 = empty1;
    assign bus.data_out_0    = rd0;
    assign bus.data_out_1    = rd1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        empty0 <= (q0.size() == 0);
        empty1 <= (q1.size() == 0);
        if (bus.pop_d0) begin
            check("pop_d0_nonempty", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) rd0 <= q0.pop_front();
        end
        if (bus.pop_d1) begin
            check("pop_d1_nonempty", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) rd1 <= q1.pop_front();
        end
    end

    // Reference model: words popped but not yet delivered, in grant order
    typedef struct { logic dst; logic [DW-1:0] d; logic cap; } ent_t;
    ent_t        sb[$];
    logic        m_last_vld, m_last_dst, m_ptr;
    logic [CW-1:0] m_cnt0, m_cnt1;
    logic        m_ev, m_xf, m_cr, m_e0, m_e1, m_g0, m_g1;
    logic [DW-1:0] m_d;

    always @(negedge clk) begin
        if (!reset_L) begin
            sb.delete();
            m_last_vld = 1'b0; m_last_dst = 1'b0; m_ptr = 1'b0;
            m_cnt0 = '0; m_cnt1 = '0;
        end else begin
            m_ev = (sb.size() > 0) && sb[0].cap;
            m_xf = m_ev && bus.ready_in;
            m_cr = (sb.size() - (m_xf ? 1 : 0)) < 2;
            m_e0 = !empty0 && !(m_last_vld && !m_last_dst) && m_cr;
            m_e1 = !empty1 && !(m_last_vld && m_last_dst) && m_cr;
`ifdef STRICT_PRIO_EN
            m_g0 = m_e0;
            m_g1 = m_e1 && !m_e0;
`else
            m_g0 = m_e0 && (!m_e1 || !m_ptr);
            m_g1 = m_e1 && (!m_e0 || m_ptr);
`endif
            check("model_pop_d0", 32'(bus.pop_d0), 32'(m_g0));
            check("model_pop_d1", 32'(bus.pop_d1), 32'(m_g1));
            check("model_valid", 32'(bus.valid_out), 32'(m_ev));
            if (m_ev) begin
                check("model_data", 32'(bus.data_out), 32'(sb[0].d));
                check("model_dest", 32'(bus.dest_out), 32'(sb[0].dst));
            end
            check("model_cnt_d0", 32'(bus.cnt_d0), 32'(m_cnt0));
            check("model_cnt_d1", 32'(bus.cnt_d1), 32'(m_cnt1));
            if (m_xf) void'(sb.pop_front());
            foreach (sb[i]) begin
                if (!sb[i].cap) begin
                    sb[i].cap = 1'b1;
                    if (sb[i].dst) m_cnt1 = m_cnt1 + 1'b1;
                    else           m_cnt0 = m_cnt0 + 1'b1;
                end
            end
            if (m_g0 || m_g1) begin
                if (m_g0) m_d = (q0.size() > 0) ? q0[0] : '0;
                else      m_d = (q1.size() > 0) ? q1[0] : '0;
                sb.push_back('{m_g1, m_d, 1'b0});
                m_ptr = m_g0;
            end
            m_last_vld = m_g0 || m_g1;
            m_last_dst = m_g1;
        end
    end

    typedef struct { logic rdy; logic p0; logic p1; logic v; logic [DW-1:0] d; logic dst; } vec_t;
    vec_t vecs[15];

    task automatic check_zero(input string name);
        check({name, "_pop_d0"}, 32'(bus.pop_d0), 32'd0);
        check({name, "_pop_d1"}, 32'(bus.pop_d1), 32'd0);
        check({name, "_valid"},  32'(bus.valid_out), 32'd0);
        check({name, "_data"},   32'(bus.data_out), 32'd0);
        check({name, "_dest"},   32'(bus.dest_out), 32'd0);
        check({name, "_cnt_d0"}, 32'(bus.cnt_d0), 32'd0);
        check({name, "_cnt_d1"}, 32'(bus.cnt_d1), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset_L = 1'b0;
        q0.delete(); q1.delete();
        bus.ready_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_L = 1'b1;
    endtask

    task automatic run_table(input int lo, input int hi, input string name);
        for (int i = lo; i <= hi; i++) begin
            @(posedge clk);
            #1 bus.ready_in = vecs[i].rdy;
            @(negedge clk);
            check({name, "_pop_d0"}, 32'(bus.pop_d0), 32'(vecs[i].p0));
            check({name, "_pop_d1"}, 32'(bus.pop_d1), 32'(vecs[i].p1));
            check({name, "_valid"},  32'(bus.valid_out), 32'(vecs[i].v));
            if (vecs[i].v) begin
                check({name, "_data"}, 32'(bus.data_out), 32'(vecs[i].d));
                check({name, "_dest"}, 32'(bus.dest_out), 32'(vecs[i].dst));
            end
        end
    endtask

    task automatic drain(input string name, input int lim);
        int idle = 0;
        bus.ready_in = 1'b1;
        for (int k = 0; k < lim && idle < 4; k++) begin
            @(negedge clk);
            if (!bus.valid_out && !bus.pop_d0 && !bus.pop_d1 && q0.size() == 0 && q1.size() == 0)
                idle++;
            else
                idle = 0;
        end
        check({name, "_drain_done"}, 32'(idle >= 4), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] got[$];
        logic [6:0] bp_exp[6];
        int order[$];
        int n_pops, viol, n1;
        logic prev_pop0;

        // single source rows 0..7, both sources rows 8..14: {rdy, pop0, pop1, valid, data, dest}
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 6'h05, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 6'h0A, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 6'h3F, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'h00, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 6'h01, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 6'h21, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 6'h02, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 6'h22, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0};
        bp_exp = '{7'h10, 7'h70, 7'h11, 7'h71, 7'h12, 7'h72};

        bus.ready_in = 1'b0;
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1 reset_L = 1'b1;

        // single source
        q0.push_back(6'h05); q0.push_back(6'h0A); q0.push_back(6'h3F);
        run_table(0, 7, "single");
        check("single_cnt_d0", 32'(bus.cnt_d0), 32'd3);
        check("single_cnt_d1", 32'(bus.cnt_d1), 32'd0);

        // both sources, starting from a fresh pointer
        do_reset();
        q0.push_back(6'h01); q0.push_back(6'h02);
        q1.push_back(6'h21); q1.push_back(6'h22);
        run_table(8, 14, "both");
        check("both_cnt_d0", 32'(bus.cnt_d0), 32'd2);
        check("both_cnt_d1", 32'(bus.cnt_d1), 32'd2);

        // backpressure: two captures then stall with the head held
        do_reset();
        q0.push_back(6'h10); q0.push_back(6'h11); q0.push_back(6'h12);
        q1.push_back(6'h30); q1.push_back(6'h31); q1.push_back(6'h32);
        n_pops = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_pops += int'(bus.pop_d0) + int'(bus.pop_d1);
            if (k >= 4) begin
                check("bp_valid", 32'(bus.valid_out), 32'd1);
                check("bp_head", 32'({bus.dest_out, bus.data_out}), 32'h10);
            end
        end
        check("bp_pops", 32'(n_pops), 32'd2);
        check("bp_captured", 32'(bus.cnt_d0 + bus.cnt_d1), 32'd2);
        @(posedge clk);
        #1 bus.ready_in = 1'b1;
        for (int k = 0; k < 30 && got.size() < 6; k++) begin
            @(negedge clk);
            if (bus.valid_out && bus.ready_in) got.push_back({bus.dest_out, bus.data_out});
        end
        check("bp_count", 32'(got.size()), 32'd6);
        for (int i = 0; i < 6 && i < got.size(); i++) check("bp_order", 32'(got[i]), 32'(bp_exp[i]));
        drain("bp", 50);

        // reset while a read is in flight
        do_reset();
        q0.push_back(6'h01); q0.push_back(6'h02); q0.push_back(6'h03);
        q1.push_back(6'h04); q1.push_back(6'h05); q1.push_back(6'h06);
        bus.ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset_L = 1'b0;
        #1 check_zero("rst_async");
        @(posedge clk);
        #1 check_zero("rst_hold");
        q0.delete(); q1.delete();
        repeat (3) @(posedge clk);
        #1 reset_L = 1'b1;
        q1.push_back(6'h15);
        @(negedge clk);
        check("rst_rel_pop_d0", 32'(bus.pop_d0), 32'd0);
        @(negedge clk);
        check("rst_rel_pop_d0_empty", 32'(bus.pop_d0), 32'd0);
        check("rst_rel_pop_d1", 32'(bus.pop_d1), 32'd1);
        drain("rst", 50);

        // counter wrap through D1
        do_reset();
        for (int i = 0; i < 256; i++) q1.push_back(DW'(i));
        bus.ready_in = 1'b1;
        for (int k = 0; k < 1000 && bus.cnt_d1 != 8'hFF; k++) @(negedge clk);
        check("wrap_reach_ff", 32'(bus.cnt_d1), 32'hFF);
        drain("wrap", 100);
        check("wrap_cnt_d1", 32'(bus.cnt_d1), 32'd0);
        check("wrap_cnt_d0", 32'(bus.cnt_d0), 32'd0);

        // both FIFOs holding 4 words: pops alternate D0, D1, ...
        do_reset();
        bus.ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin q0.push_back(DW'(i)); q1.push_back(DW'(6'h20 + i)); end
        for (int k = 0; k < 40 && order.size() < 8; k++) begin
            @(negedge clk);
            if (bus.pop_d0) order.push_back(0);
            if (bus.pop_d1) order.push_back(1);
        end
        check("alt_count", 32'(order.size()), 32'd8);
        for (int i = 0; i < order.size(); i++) check("alt_order", 32'(order[i]), 32'(i % 2));
        drain("alt", 50);

        // D0 refilled continuously: D1 only in D0 guard cycles
        do_reset();
        bus.ready_in = 1'b1;
        for (int i = 0; i < 4; i++) q1.push_back(DW'(6'h30 + i));
        viol = 0; n1 = 0; prev_pop0 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (q0.size() < 3) q0.push_back(DW'($urandom_range(0, 63)));
            @(negedge clk);
            if (bus.pop_d1 && !prev_pop0) viol++;
            if (bus.pop_d1) n1++;
            prev_pop0 = bus.pop_d0;
            @(posedge clk);
            #1;
        end
        check("refill_d1_outside_guard", 32'(viol), 32'd0);
        check("refill_d1_pops", 32'(n1), 32'd4);
        drain("refill", 50);

        // random traffic against the reference model
        do_reset();
        for (int k = 0; k < 2500; k++) begin
            bus.ready_in = ($urandom_range(0, 99) < 70);
            if (q0.size() < 6 && $urandom_range(0, 99) < 40) q0.push_back(DW'($urandom_range(0, 63)));
            if (q1.size() < 6 && $urandom_range(0, 99) < 35) q1.push_back(DW'($urandom_range(0, 63)));
            @(posedge clk);
            #1;
        end
        drain("rand", 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
